// File: rtl/seg7_scan_driver_if.sv
// Display-side bundle for seg7_scan_driver: value/control inputs and scanned pin outputs.
interface seg7_scan_driver_if #(
  parameter int unsigned DIGITS = 4
);
  logic                  load;
  logic [4*DIGITS-1:0]   value;
  logic [DIGITS-1:0]     dp_in;
  logic                  hex_mode;
  logic                  blank_lz;
  logic [3:0]            brightness;
  logic [6:0]            segments;
  logic                  dp;
  logic [DIGITS-1:0]     digit_en;
  logic                  frame_start;

  modport master (
    output load, value, dp_in, hex_mode, blank_lz, brightness,
    input  segments, dp, digit_en, frame_start
  );

  modport slave (
    input  load, value, dp_in, hex_mode, blank_lz, brightness,
    output segments, dp, digit_en, frame_start
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment scan driver: double-buffered value, hex/decimal decode,
// leading-zero blanking and 16-step PWM dimming, all outputs registered.
module seg7_scan_driver #(
  parameter int unsigned DIGITS  = 4,
  parameter int unsigned SUB_DIV = 1000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  seg7_scan_driver_if.slave disp_if
);
  localparam int unsigned STEP_W = (SUB_DIV > 1) ? $clog2(SUB_DIV) : 1;
  localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned VAL_W  = 4 * DIGITS;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(SUB_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);

  logic [STEP_W-1:0] step_q, step_d;
  logic [3:0]        pwm_q, pwm_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [VAL_W-1:0]  shadow_val_q, shadow_val_d;
  logic [DIGITS-1:0] shadow_dp_q, shadow_dp_d;
  logic [VAL_W-1:0]  active_val_q, active_val_d;
  logic [DIGITS-1:0] active_dp_q, active_dp_d;
  logic              pending_q, pending_d;
  logic [6:0]        segments_q, segments_d;
  logic              dp_q, dp_d;
  logic [DIGITS-1:0] digit_en_q, digit_en_d;
  logic              frame_start_q, frame_start_d;

  logic              step_wrap, slot_wrap, frame_wrap;
  logic [3:0]        cur_nib;
  logic              cur_dp, cur_blank, upper_zero, lit;
  logic [DIGITS-1:0] zero_from;

  function automatic logic [6:0] decode(input logic [3:0] nib, input logic hex);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b0111111;
      4'h1:    seg = 7'b0000110;
      4'h2:    seg = 7'b1011011;
      4'h3:    seg = 7'b1001111;
      4'h4:    seg = 7'b1100110;
      4'h5:    seg = 7'b1101101;
      4'h6:    seg = 7'b1111101;
      4'h7:    seg = 7'b0000111;
      4'h8:    seg = 7'b1111111;
      4'h9:    seg = 7'b1101111;
      4'hA:    seg = 7'b1110111;
      4'hB:    seg = 7'b1111100;
      4'hC:    seg = 7'b0111001;
      4'hD:    seg = 7'b1011110;
      4'hE:    seg = 7'b1111001;
      default: seg = 7'b1110001;
    endcase
    if (!hex && nib > 4'd9) seg = 7'b1000000;
    return seg;
  endfunction

  // Scan counters: step -> pwm step -> digit slot.
  always_comb begin
    step_wrap  = (step_q == STEP_LAST);
    slot_wrap  = step_wrap && (pwm_q == 4'hF);
    frame_wrap = slot_wrap && (idx_q == IDX_LAST);
    step_d     = step_wrap ? '0 : step_q + STEP_W'(1);
    pwm_d      = step_wrap ? pwm_q + 4'd1 : pwm_q;
    idx_d      = idx_q;
    if (slot_wrap) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
  end

  // Double buffer; a load coinciding with the frame wrap bypasses the shadow.
  always_comb begin
    shadow_val_d = shadow_val_q;
    shadow_dp_d  = shadow_dp_q;
    active_val_d = active_val_q;
    active_dp_d  = active_dp_q;
    pending_d    = pending_q;
    if (disp_if.load) begin
      shadow_val_d = disp_if.value;
      shadow_dp_d  = disp_if.dp_in;
      pending_d    = 1'b1;
    end
    if (frame_wrap) begin
      if (disp_if.load) begin
        active_val_d = disp_if.value;
        active_dp_d  = disp_if.dp_in;
        pending_d    = 1'b0;
      end else if (pending_q) begin
        active_val_d = shadow_val_q;
        active_dp_d  = shadow_dp_q;
        pending_d    = 1'b0;
      end
    end
  end

  // Digit selection, leading-zero run from the top, and PWM gating.
  always_comb begin
    cur_nib    = 4'h0;
    cur_dp     = 1'b0;
    cur_blank  = 1'b0;
    upper_zero = 1'b1;
    zero_from  = '0;
    for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
      zero_from[k] = upper_zero && (active_val_q[4*k +: 4] == 4'h0);
      upper_zero   = zero_from[k];
    end
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (idx_q == IDX_W'(k)) begin
        cur_nib   = active_val_q[4*k +: 4];
        cur_dp    = active_dp_q[k];
        cur_blank = (k != 0) && zero_from[k];
      end
    end
    lit = (pwm_q <= disp_if.brightness);
    digit_en_d = '0;
    for (int k = 0; k < int'(DIGITS); k++) begin
      digit_en_d[k] = lit && (idx_q == IDX_W'(k));
    end
    segments_d    = (lit && !(disp_if.blank_lz && cur_blank)) ?
                    decode(cur_nib, disp_if.hex_mode) : 7'b0000000;
    dp_d          = lit && cur_dp;
    frame_start_d = (idx_q == '0) && (pwm_q == 4'h0) && (step_q == '0);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      step_q        <= '0;
      pwm_q         <= '0;
      idx_q         <= '0;
      shadow_val_q  <= '0;
      shadow_dp_q   <= '0;
      active_val_q  <= '0;
      active_dp_q   <= '0;
      pending_q     <= 1'b0;
      segments_q    <= '0;
      dp_q          <= 1'b0;
      digit_en_q    <= '0;
      frame_start_q <= 1'b0;
    end else begin
      step_q        <= step_d;
      pwm_q         <= pwm_d;
      idx_q         <= idx_d;
      shadow_val_q  <= shadow_val_d;
      shadow_dp_q   <= shadow_dp_d;
      active_val_q  <= active_val_d;
      active_dp_q   <= active_dp_d;
      pending_q     <= pending_d;
      segments_q    <= segments_d;
      dp_q          <= dp_d;
      digit_en_q    <= digit_en_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign disp_if.segments    = segments_q;
  assign disp_if.dp          = dp_q;
  assign disp_if.digit_en    = digit_en_q;
  assign disp_if.frame_start = frame_start_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver (DIGITS=4, SUB_DIV=2): per-cycle expectations queued from
// a vector table and hand-built sequences, compared at the falling edge.
module tb_seg7_scan_driver;
  localparam int unsigned DIGITS  = 4;
  localparam int unsigned SUB_DIV = 2;
  localparam int FRAME = 128;
  localparam int SLOT  = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   c;
  int   n_chk = 0;
  int   n_err = 0;

  seg7_scan_driver_if #(.DIGITS(DIGITS)) dif ();
  seg7_scan_driver #(.DIGITS(DIGITS), .SUB_DIV(SUB_DIV)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .disp_if (dif)
  );

  always #5 clk = ~clk;

  // c = rising edges since reset release; output cycle c shows counter state c-1.
  always @(posedge clk or posedge rst) begin
    if (rst) c <= 0;
    else     c <= c + 1;
  end

  typedef struct {
    int         cyc;
    int         tag;
    logic [3:0] en;
    logic [6:0] seg;
    logic       dp;
    logic       fs;
  } exp_t;

  typedef struct {
    logic [15:0]     value;
    logic [3:0]      dpi;
    logic            hex;
    logic            blank;
    logic [3:0]      bright;
    logic [3:0][6:0] segs;
  } vec_t;

  exp_t sb[$];
  exp_t me;
  vec_t vt[8];
  vec_t v_zero, v_1111, v_2222, v_4444, v_7777;

  task automatic chk(input string nm, input int tag, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s tag=%0d cyc=%0d got=%0h exp=%0h", nm, tag, c, act, exp_v);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      while (sb.size() > 0 && sb[0].cyc <= c) begin
        me = sb.pop_front();
        if (me.cyc != c) begin
          chk("sample_missed", me.tag, 32'(c), 32'(me.cyc));
        end else begin
          chk("digit_en", me.tag, 32'(dif.digit_en), 32'(me.en));
          chk("segments", me.tag, 32'(dif.segments), 32'(me.seg));
          chk("dp", me.tag, 32'(dif.dp), 32'(me.dp));
          chk("frame_start", me.tag, 32'(dif.frame_start), 32'(me.fs));
        end
      end
    end
  end

  // Queue samples of frame f, digits dmin..3: slot edges, around the PWM cut, last clock.
  function automatic void push_frame(input int f, input int dmin, input vec_t v, input int tag);
    exp_t e;
    bit   take;
    int   br;
    br = int'(v.bright);
    for (int d = dmin; d < 4; d++) begin
      for (int p = 0; p < 16; p++) begin
        for (int st = 0; st < 2; st++) begin
          take = (st == 0) ? (p == 0 || p == br || p == br + 1 || p == 15)
                           : (p == br || p == 15);
          if (take) begin
            e.cyc = f * FRAME + d * SLOT + p * int'(SUB_DIV) + st + 1;
            e.tag = tag;
            e.en  = (p <= br) ? 4'(1 << d) : 4'b0000;
            e.seg = (p <= br) ? v.segs[d] : 7'b0000000;
            e.dp  = (p <= br) ? v.dpi[d] : 1'b0;
            e.fs  = (d == 0 && p == 0 && st == 0);
            sb.push_back(e);
          end
        end
      end
    end
  endfunction

  task automatic wait_c(input int t);
    int guard;
    guard = 0;
    while (c < t && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    if (c < t) chk("wait_timeout", t, 32'(c), 32'(t));
  endtask

  task automatic apply(input vec_t v);
    dif.value      = v.value;
    dif.dp_in      = v.dpi;
    dif.hex_mode   = v.hex;
    dif.blank_lz   = v.blank;
    dif.brightness = v.bright;
  endtask

  task automatic pulse_load();
    dif.load = 1'b1;
    @(negedge clk);
    dif.load = 1'b0;
  endtask

  task automatic do_vec(input vec_t v, input int tag);
    int f;
    apply(v);
    f = c / FRAME;
    push_frame(f + 1, 0, v, tag);
    pulse_load();
    wait_c((f + 2) * FRAME + 1);
  endtask

  function automatic vec_t mk(input logic [15:0] val, input logic [3:0] dpi, input logic hex,
                              input logic blank, input logic [3:0] br,
                              input logic [6:0] s3, input logic [6:0] s2,
                              input logic [6:0] s1, input logic [6:0] s0);
    vec_t v;
    v.value = val; v.dpi = dpi; v.hex = hex; v.blank = blank; v.bright = br;
    v.segs  = {s3, s2, s1, s0};
    return v;
  endfunction

  initial begin
    int f;
    vt[0] = mk(16'h3210, 4'b0000, 1'b0, 1'b0, 4'd15, 7'b1001111, 7'b1011011, 7'b0000110, 7'b0111111);
    vt[1] = mk(16'hFEDC, 4'b0000, 1'b1, 1'b0, 4'd15, 7'b1110001, 7'b1111001, 7'b1011110, 7'b0111001);
    vt[2] = mk(16'hFEDC, 4'b0000, 1'b0, 1'b0, 4'd15, 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000);
    vt[3] = mk(16'h0050, 4'b1000, 1'b0, 1'b1, 4'd15, 7'b0000000, 7'b0000000, 7'b1101101, 7'b0111111);
    vt[4] = mk(16'h0000, 4'b0000, 1'b0, 1'b1, 4'd15, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0111111);
    vt[5] = mk(16'h9876, 4'b0000, 1'b0, 1'b0, 4'd3,  7'b1101111, 7'b1111111, 7'b0000111, 7'b1111101);
    vt[6] = mk(16'hBA54, 4'b0101, 1'b1, 1'b0, 4'd0,  7'b1111100, 7'b1110111, 7'b1101101, 7'b1100110);
    vt[7] = mk(16'h0100, 4'b0010, 1'b0, 1'b1, 4'd7,  7'b0000000, 7'b0000110, 7'b0111111, 7'b0111111);
    v_zero = mk(16'h0000, 4'b0000, 1'b0, 1'b0, 4'd15, 7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111);
    v_1111 = mk(16'h1111, 4'b0000, 1'b0, 1'b0, 4'd15, 7'b0000110, 7'b0000110, 7'b0000110, 7'b0000110);
    v_2222 = mk(16'h2222, 4'b0000, 1'b0, 1'b0, 4'd15, 7'b1011011, 7'b1011011, 7'b1011011, 7'b1011011);
    v_4444 = mk(16'h4444, 4'b0000, 1'b0, 1'b0, 4'd15, 7'b1100110, 7'b1100110, 7'b1100110, 7'b1100110);
    v_7777 = mk(16'h7777, 4'b1111, 1'b0, 1'b0, 4'd15, 7'b0000111, 7'b0000111, 7'b0000111, 7'b0000111);

    dif.load = 1'b0;
    apply(v_zero);
    repeat (3) @(negedge clk);
    chk("rst_digit_en", 0, 32'(dif.digit_en), 32'd0);
    chk("rst_segments", 0, 32'(dif.segments), 32'd0);
    chk("rst_dp", 0, 32'(dif.dp), 32'd0);
    chk("rst_frame_start", 0, 32'(dif.frame_start), 32'd0);

    // Free-running scan of the reset value.
    rst = 1'b0;
    push_frame(0, 0, v_zero, 100);
    push_frame(1, 0, v_zero, 101);
    wait_c(2 * FRAME + 1);

    for (int i = 0; i < 8; i++) do_vec(vt[i], i);

    // Two loads mid-frame: old value finishes the frame, last load wins next frame.
    do_vec(vt[0], 10);
    wait_c(c - (c % FRAME) + 40);
    f = c / FRAME;
    push_frame(f, 2, vt[0], 200);
    push_frame(f + 1, 0, v_2222, 201);
    apply(v_1111);
    pulse_load();
    repeat (2) @(negedge clk);
    apply(v_2222);
    pulse_load();
    wait_c((f + 2) * FRAME + 1);

    // Load sampled on the frame-wrap edge shows in the very next frame.
    wait_c(c - (c % FRAME) + FRAME - 1);
    f = c / FRAME;
    push_frame(f + 1, 0, v_4444, 300);
    apply(v_4444);
    pulse_load();
    wait_c((f + 2) * FRAME + 1);

    // Reset mid-frame with a load pending.
    wait_c(c - (c % FRAME) + 45);
    apply(v_7777);
    pulse_load();
    wait_c(c - (c % FRAME) + 50);
    chk("pre_rst_lit", 0, 32'(dif.digit_en != 4'b0000), 32'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_digit_en", 0, 32'(dif.digit_en), 32'd0);
    chk("async_rst_segments", 0, 32'(dif.segments), 32'd0);
    chk("async_rst_dp", 0, 32'(dif.dp), 32'd0);
    chk("async_rst_frame_start", 0, 32'(dif.frame_start), 32'd0);
    repeat (2) @(negedge clk);
    apply(v_zero);
    rst = 1'b0;
    push_frame(0, 0, v_zero, 400);
    push_frame(1, 0, v_zero, 401);
    wait_c(2 * FRAME + 1);

    chk("scoreboard_drained", 0, 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Parametrised, time-multiplexed driver for a common-segment array of DIGITS 7-segment digits. It holds a double-buffered display value, decodes one 4-bit nibble per digit in decimal or hex mode, and scans the digit enables one at a time. It also blanks leading zeros and dims the display with a 16-step PWM. It sits between the counter/datapath logic and the display pins, and replaces per-digit combinational decoders.

## Interface
- DIGITS, 4: number of digits; legal range 1..8.
- SUB_DIV, 1000: clocks per PWM step, ≥1. One digit slot is 16*SUB_DIV clocks; one frame is DIGITS slots.
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- load  in  1  single-cycle strobe; captures value/dp_in into the shadow buffer.
- value  in  4*DIGITS  nibble k (bits 4k+3:4k) is digit k; digit 0 is least significant.
- dp_in  in  DIGITS  decimal point per digit.
- hex_mode  in  1  1 = nibbles 10..15 show A,b,C,d,E,F; 0 = they show a dash.
- blank_lz  in  1  1 = leading-zero blanking enabled.
- brightness  in  4  on-time is (brightness+1)/16 of each slot.
- segments  out  7  active-high segments; bit0=a(top), bit1=b(upper right), bit2=c(lower right), bit3=d(bottom), bit4=e(lower left), bit5=f(upper left), bit6=g(middle).
- dp  out  1  active-high decimal point of the enabled digit.
- digit_en  out  DIGITS  one-hot or all-zero enable; bit k drives digit k.
- frame_start  out  1  one-clock pulse on the first cycle of digit 0's slot.

## Operation
- Counters:
  - step_cnt runs 0..SUB_DIV-1.
  - pwm_cnt runs 0..15 and advances when step_cnt wraps.
  - digit_idx runs 0..DIGITS-1 and advances when pwm_cnt and step_cnt both wrap; it wraps DIGITS-1 → 0.
- Buffering:
  - load=1 copies value and dp_in into the shadow registers and sets the pending flag.
  - If several loads occur within one frame, the last one wins.
  - At the frame wrap (digit_idx DIGITS-1 → 0 with all counters wrapping), a set pending flag copies shadow into the active registers and clears pending.
  - A load in the same cycle as the wrap is committed directly; the new value is active from the frame that starts next.
  - No tearing: a frame always displays a single active value.
- Decode, applied to the active nibble of digit_idx:
  - 0:0111111, 1:0000110, 2:1011011, 3:1001111, 4:1100110, 5:1101101, 6:1111101, 7:0000111, 8:1111111, 9:1101111.
  - With hex_mode=1: A:1110111, b:1111100, C:0111001, d:1011110, E:1111001, F:1110001.
  - With hex_mode=0, nibbles 10..15 produce 1000000 (dash).
  - hex_mode and brightness take effect immediately; they are not buffered.
- Leading-zero blanking (blank_lz=1):
  - Digit k is blanked (segments=0) when all active nibbles k..DIGITS-1 are zero.
  - Digit 0 is never blanked.
  - dp is unaffected by blanking.
- PWM:
  - digit_en[digit_idx]=1 only while pwm_cnt ≤ brightness; otherwise digit_en=0.
  - segments and dp are forced to 0 whenever digit_en=0.

## Timing
- Reset values, asynchronous:
  - Counters are 0 and pending is 0.
  - Shadow and active registers are 0.
  - segments, dp, digit_en and frame_start are 0.
- All outputs are registered. Each output reflects the counter state of the previous cycle, so there is one clock of latency from a counter change to the pins.
- After reset release, the first clock edge loads outputs for digit 0, pwm step 0. frame_start=1 in that same output cycle.
- digit_en, segments and dp change on the same edge, so there is no ghosting cycle between digits.
- Load-to-display latency: at most one frame plus one clock.
- Reset asserted mid-frame:
  - All outputs drop to 0 immediately.
  - The pending load is discarded.
- DIGITS=1: digit_idx stays 0 and frame_start pulses every slot.
- SUB_DIV=1: step_cnt is constant 0 and pwm_cnt advances every clock.

## Test plan
- Reset release, DIGITS=4, SUB_DIV=2, brightness=15, no load:
  - digit_en cycles 0001, 0010, 0100, 1000, 32 clocks each.
  - segments=0111111 throughout and dp=0.
  - frame_start pulses every 128 clocks.
- Decode sweep:
  - Load value=16'h3210 with hex_mode=0; after the next frame_start, the digits show 0111111, 0000110, 1011011, 1001111.
  - Load 16'hFEDC with hex_mode=1; digits show C, d, E, F.
  - Set hex_mode=0; all four digits show 1000000.
- Leading-zero blanking: blank_lz=1, value=16'h0050, dp_in=4'b1000:
  - Digits 3 and 2 have segments=0; digit 3 has dp=1.
  - Digit 1 shows 5 and digit 0 shows 0.
  - With value=16'h0000, only digit 0 shows 0.
- Buffering:
  - Load 16'h1111 mid-frame, then 16'h2222 three clocks later; the current frame still shows the old value and the next frame shows all 2s.
  - A load on the wrap cycle is visible in the immediately following frame.
- PWM: brightness=3, SUB_DIV=2:
  - The enable of each slot is high for 8 clocks and low for 24 clocks.
  - segments=0 during the low time.
  - brightness=0 gives 2 clocks high per slot.
- Reset asserted 50 clocks into a frame with a load pending:
  - Outputs are 0 asynchronously.
  - After release, the display shows 0 and the pending value is never shown.
